bcd_timer_display: RTL and testbench

//   Parametrised successor to the single-digit timer top: DIGITS-wide decimal

---
 rtl/bcd_timer_display.sv | 161 ++++++++++++++++
 tb/tb_bcd_timer_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_display.sv
// Multi-digit BCD up/down timer with internal tick prescaler, parallel load,
// wrap flag and a time-multiplexed active-low 7-segment scanner.
module bcd_timer_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tick,
    output logic                  wrap,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_q;
    logic [PW-1:0]       r_p;
    logic                r_tick;
    logic                r_wrap;
    logic [SW-1:0]       r_scan_t;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;

    logic [4*DIGITS:0]   w_step;
    logic                w_scan_term;
    logic [IW-1:0]       w_next_idx;
    logic [3:0]          w_digit;

    // Returns {wrapped, next value}; carry/borrow ripples through all digits.
    function automatic logic [4*DIGITS:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic dir_up);
        logic [4*DIGITS-1:0] res;
        logic                c;
        logic [3:0]          d;
        res = v;
        c   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (dir_up) begin
                    if (d >= 4'd9) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            res[4*i +: 4] = d;
        end
        return {c, res};
    endfunction

    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        res = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) res[4*i +: 4] = 4'd9;
        end
        return res;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    assign w_step      = bcd_step(r_q, up);
    assign w_scan_term = (r_scan_t == SCAN_LAST);
    assign w_next_idx  = !w_scan_term ? r_idx :
                         (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_next_idx == IW'(i)) w_digit = r_q[4*i +: 4];
        end
    end

    // Counter: clr > load > prescaled step
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q    <= '0;
            r_p    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= bcd_clamp(load_val);
            r_p    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (r_p == TICK_LAST) begin
                r_p    <= '0;
                r_q    <= w_step[4*DIGITS-1:0];
                r_tick <= 1'b1;
                r_wrap <= w_step[4*DIGITS];
            end else begin
                r_p    <= r_p + PW'(1);
                r_tick <= 1'b0;
                r_wrap <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    // Scanner: glyph follows the lit digit every cycle, using pre-update q
    always_ff @(posedge clk) begin
        if (clr) begin
            r_scan_t <= '0;
            r_idx    <= '0;
            r_an     <= ~DIGITS'(1);
            r_seg    <= 7'b0000001;
        end else begin
            r_scan_t <= w_scan_term ? '0 : r_scan_t + SW'(1);
            r_idx    <= w_next_idx;
            r_an     <= ~(DIGITS'(1) << w_next_idx);
            r_seg    <= glyph(w_digit);
        end
    end

    assign q      = r_q;
    assign tick   = r_tick;
    assign wrap   = r_wrap;
    assign an     = r_an;
    assign a_to_g = r_seg;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Directed bench for bcd_timer_display at DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_timer_display;

    logic       clk = 1'b0;
    logic       clr, load, en, up;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       tick, wrap;
    logic [6:0] a_to_g;
    logic [1:0] an;

    int n_vec  = 0;
    int n_fail = 0;

    bcd_timer_display #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .q(q), .tick(tick), .wrap(wrap), .a_to_g(a_to_g), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic       up;
        int         ncyc;
        logic [7:0] exp_q;
        logic       exp_tick;
        logic       exp_wrap;
        int         exp_nticks;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    function automatic vec_t mk(input logic c, input logic l, input logic [7:0] lv,
                                input logic e, input logic u, input int n,
                                input logic [7:0] eq, input logic et, input logic ew,
                                input int ent);
        vec_t v;
        v.clr = c; v.load = l; v.lv = lv; v.en = e; v.up = u; v.ncyc = n;
        v.exp_q = eq; v.exp_tick = et; v.exp_wrap = ew; v.exp_nticks = ent;
        return v;
    endfunction

    initial begin
        int         nt;
        int         changes;
        logic [1:0] prev_an;

        clr = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b1; up = 1'b1;

        // clr  load lv     en  up  n   q      tick  wrap ticks
        vecs.push_back(mk(1, 0, 8'h00, 1, 1,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  3, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  1, 8'h01, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 16, 8'h05, 1, 0, 4));
        vecs.push_back(mk(0, 1, 8'h98, 1, 1,  1, 8'h98, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  4, 8'h99, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  4, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  3, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  1, 8'h01, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0,  1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  4, 8'h99, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  4, 8'h98, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'hAB, 1, 1,  1, 8'h99, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  2, 8'h99, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 40, 8'h99, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  1, 8'h99, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  1, 8'h00, 1, 1, 1));
        vecs.push_back(mk(0, 1, 8'h12, 1, 1,  6, 8'h12, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  3, 8'h12, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1,  1, 8'h13, 1, 0, 1));

        foreach (vecs[k]) begin
            clr = vecs[k].clr; load = vecs[k].load; load_val = vecs[k].lv;
            en = vecs[k].en;   up = vecs[k].up;
            nt = 0;
            for (int c = 0; c < vecs[k].ncyc; c++) begin
                step();
                if (tick) nt++;
            end
            chk($sformatf("v%0d.q", k),     q,    vecs[k].exp_q);
            chk($sformatf("v%0d.tick", k),  tick, vecs[k].exp_tick);
            chk($sformatf("v%0d.wrap", k),  wrap, vecs[k].exp_wrap);
            chk($sformatf("v%0d.nticks", k), nt,  vecs[k].exp_nticks);
            if (k == 0) begin
                chk("reset.an",     an,     2'b10);
                chk("reset.a_to_g", a_to_g, 7'b0000001);
            end
        end

        // Static 37: anode alternation and glyph/anode pairing
        clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'h37;
        step();
        load = 1'b0;
        step();
        step();
        prev_an = an;
        changes = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (an != prev_an) changes++;
            prev_an = an;
            if (an == 2'b10)      chk("scan.digit0", a_to_g, seg_of(4'd7));
            else if (an == 2'b01) chk("scan.digit1", a_to_g, seg_of(4'd3));
            else                  chk("scan.an_onehot", an, 2'b10);
        end
        chk("scan.changes", changes, 4);
        chk("scan.q", q, 8'h37);

        // clr landing on the prescaler's terminal edge
        load = 1'b1; load_val = 8'h00; en = 1'b1; up = 1'b1;
        step();
        load = 1'b0;
        step(); step(); step();
        clr = 1'b1;
        step();
        chk("clr.q",      q,      8'h00);
        chk("clr.tick",   tick,   1'b0);
        chk("clr.wrap",   wrap,   1'b0);
        chk("clr.an",     an,     2'b10);
        chk("clr.a_to_g", a_to_g, 7'b0000001);
        clr = 1'b0;
        nt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (tick) nt++;
        end
        chk("clr.no_residual_tick", nt, 0);
        step();
        chk("clr.first_tick", tick, 1'b1);
        chk("clr.first_q",    q,    8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
